// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame format.
// uart_tx and uart_rx both take their DATA_BITS/STOP_BITS defaults from here.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned DEF_DATA_BITS    = 8;
  localparam int unsigned DEF_STOP_BITS    = 1;
  localparam int unsigned DEF_CLKS_PER_BIT = 1000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Both flops reset to RESET_VAL so an idle-high line reads idle out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation at mid-bit, LSB-first data at bit centres,
// stop-bit check, and a single-entry valid/ready holding register.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
  parameter int unsigned STOP_BITS    = DEF_STOP_BITS,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  rx_state_t            state_q, state_d;
  logic                 rxs, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 start_det, sample, last_data, last_stop;
  logic                 frame_good, frame_bad;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (in),
    .q    (rxs)
  );

  assign start_det = (state_q == IDLE) && !rxs && rxs_prev_q;
  // Counter is held at 0 in IDLE, so it reads H-1 exactly H cycles after D and
  // every CLKS_PER_BIT cycles after that.
  assign sample    = (state_q != IDLE) && (cnt_q == CW'(H - 1));
  assign last_data = (bit_cnt_q == BW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == SW'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_det) state_d = START;
      START: if (sample) state_d = rxs ? IDLE : DATA;
      DATA:  if (sample && last_data) state_d = STOP;
      STOP:  if (sample && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = '0;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    err_d      = err_q;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      START: begin
        if (sample) bit_cnt_d = '0;
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_cnt_q] = rxs;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (last_data) begin
            stop_cnt_d = '0;
            err_d      = 1'b0;
          end
        end
      end
      STOP: begin
        if (sample) begin
          err_d      = err_q | ~rxs;
          stop_cnt_d = stop_cnt_q + 1'b1;
          if (last_stop) begin
            frame_bad  = err_d;
            frame_good = ~err_d;
          end
        end
      end
      default: ;
    endcase
  end

  // Holding register; a load and a consume in the same cycle keep valid high.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (valid_q && ready) valid_d = 1'b0;
    if (frame_bad) begin
      frame_err_d = 1'b1;
    end else if (frame_good) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxs_prev_q  <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxs_prev_q  <= rxs;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: each driven frame queues its expected outcome,
// and a negedge monitor pops and compares when the receiver reports.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int H   = CPB / 2;
  // Line change to visible output: 2 sync clocks + H + 9 bits + 1 register.
  localparam int LAT = 2 + H + (8 + 1) * CPB + 1;

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned at;
    logic        vld;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        sb[$];

  uart_rx #(
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (line),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_bit(input logic v, input int dur);
    line = v;
    repeat (dur) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit k lasts base clocks, plus one on odd k when alt is set (mean base+0.5).
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int base,
                            input bit alt, input int kind, input logic [7:0] exp_d,
                            input logic exp_v);
    sb.push_back('{kind: kind, data: exp_d, at: cyc + LAT, vld: exp_v});
    drive_bit(1'b0, base);
    for (int i = 0; i < 8; i++) drive_bit(b[i], base + ((alt && (i % 2 == 0)) ? 1 : 0));
    drive_bit(stop_v, base + (alt ? 1 : 0));
    line = 1'b1;
  endtask

  // Monitor: any valid rise or pulse must match the oldest expected outcome.
  initial begin
    logic valid_prev;
    logic ev;
    int   follow;
    int   kind_got;
    exp_t e;
    valid_prev = 1'b0;
    follow     = 0;
    forever begin
      @(negedge clk);
      unique case (follow)
        1: check_eq("valid_one_cycle", valid, 1'b0);
        2: check_eq("ferr_one_cycle", frame_err, 1'b0);
        3: check_eq("ovr_one_cycle", overrun, 1'b0);
        default: ;
      endcase
      follow = 0;
      ev = (valid === 1'b1 && valid_prev === 1'b0) || frame_err === 1'b1 || overrun === 1'b1;
      if (ev) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_output", ev, 1'b0);
        end else begin
          e        = sb.pop_front();
          kind_got = frame_err ? K_FERR : (overrun ? K_OVR : K_DATA);
          check_eq("event_kind", kind_got, e.kind);
          check_eq("event_latency", cyc, e.at);
          check_eq("event_valid", valid, e.vld);
          if (e.kind != K_FERR) check_eq("event_data", data_out, e.data);
          if (e.kind == K_FERR) follow = 2;
          else if (e.kind == K_OVR) follow = 3;
          else if (ready) follow = 1;
        end
      end
      valid_prev = valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_data", data_out, 8'h00);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    rst_n = 1'b1;
    drive_bit(1'b1, 10);

    // Basic frame with consumer ready.
    send_frame(8'hA5, 1'b1, CPB, 1'b0, K_DATA, 8'hA5, 1'b1);
    drive_bit(1'b1, 20);

    // Short glitch must be rejected at the start-bit midpoint.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    send_frame(8'h3C, 1'b1, CPB, 1'b0, K_DATA, 8'h3C, 1'b1);
    drive_bit(1'b1, 20);

    // Stop bit low.
    send_frame(8'h5A, 1'b0, CPB, 1'b0, K_FERR, 8'h00, 1'b0);
    drive_bit(1'b1, 40);

    // Back-to-back into a full holding register.
    ready = 1'b0;
    send_frame(8'h11, 1'b1, CPB, 1'b0, K_DATA, 8'h11, 1'b1);
    send_frame(8'h22, 1'b1, CPB, 1'b0, K_OVR, 8'h11, 1'b1);
    check_eq("ovr_keep_valid", valid, 1'b1);
    check_eq("ovr_keep_data", data_out, 8'h11);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("consume_valid", valid, 1'b0);
    drive_bit(1'b1, 20);

    // Reset during data bit 4 with a byte still held.
    ready = 1'b0;
    send_frame(8'h96, 1'b1, CPB, 1'b0, K_DATA, 8'h96, 1'b1);
    drive_bit(1'b1, 20);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(logic'((8'hC3 >> i) & 8'h01), CPB);
    drive_bit(1'b0, H);
    rst_n = 1'b0;
    line  = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("midrst_valid", valid, 1'b0);
    check_eq("midrst_data", data_out, 8'h00);
    check_eq("midrst_ferr", frame_err, 1'b0);
    check_eq("midrst_ovr", overrun, 1'b0);
    drive_bit(1'b1, 30);
    ready = 1'b1;
    send_frame(8'hC3, 1'b1, CPB, 1'b0, K_DATA, 8'hC3, 1'b1);
    drive_bit(1'b1, 20);

    // Baud mismatch; whole-clock 15/17 exceeds the (H-1)/(9.5*CPB) tolerance,
    // so the transmitter averages 15.5 and 16.5 clocks per bit.
    send_frame(8'hFF, 1'b1, CPB - 1, 1'b1, K_DATA, 8'hFF, 1'b1);
    send_frame(8'h00, 1'b1, CPB - 1, 1'b1, K_DATA, 8'h00, 1'b1);
    drive_bit(1'b1, 20);
    send_frame(8'hFF, 1'b1, CPB, 1'b1, K_DATA, 8'hFF, 1'b1);
    send_frame(8'h00, 1'b1, CPB, 1'b1, K_DATA, 8'h00, 1'b1);
    drive_bit(1'b1, 60);

    check_eq("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
